// File: rtl/tmr_dmem_scrubber.sv
// Triplicated data memory with 2-of-3 voted reads, a background scrubber that
// repairs single-copy corruption, and a fault-injection port.
module tmr_dmem_scrubber #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_LSB = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         DM_addr,
  input  logic [WIDTH-1:0]         DM_writeData,
  input  logic                     DM_writeEnable,
  input  logic                     DM_readEnable,
  output logic [WIDTH-1:0]         DM_readData,
  input  logic                     scrub_en,
  input  logic                     clear_counts,
  input  logic                     inject_en,
  input  logic [1:0]               inject_copy,
  input  logic [$clog2(DEPTH)-1:0] inject_addr,
  input  logic [WIDTH-1:0]         inject_mask,
  output logic                     init_busy,
  output logic                     read_fault,
  output logic [$clog2(DEPTH)-1:0] scrub_ptr,
  output logic [15:0]              corrected_count,
  output logic [15:0]              uncorrectable_count,
  output logic                     uncorrectable_flag
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = 16;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCRUB} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] mem [3][DEPTH];
  logic [AW-1:0]    init_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd0, rd1, rd2;
  logic [WIDTH-1:0] sc0, sc1, sc2;
  logic [WIDTH-1:0] sc_vote;
  logic             rd_mis, sc_all, sc_maj;
  logic             wr_go, inj_go, scrub_step, scrub_fix, scrub_bad;
  logic             unused_addr_bits;

  function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    if (a == b || a == c) return a;
    if (b == c) return b;
    return a;
  endfunction

  // Upper address bits alias onto the same index; byte-offset bits are dropped.
  assign rd_idx           = DM_addr[ADDR_LSB +: AW];
  assign unused_addr_bits = ^{DM_addr[WIDTH-1:ADDR_LSB+AW], DM_addr[ADDR_LSB-1:0]};

  assign rd0 = mem[0][rd_idx];
  assign rd1 = mem[1][rd_idx];
  assign rd2 = mem[2][rd_idx];
  assign sc0 = mem[0][scrub_ptr];
  assign sc1 = mem[1][scrub_ptr];
  assign sc2 = mem[2][scrub_ptr];

  assign rd_mis  = !(rd0 == rd1 && rd1 == rd2);
  assign sc_all  = (sc0 == sc1) && (sc1 == sc2);
  assign sc_maj  = (sc0 == sc1) || (sc0 == sc2) || (sc1 == sc2);
  assign sc_vote = vote3(sc0, sc1, sc2);

  assign DM_readData = (state == ST_INIT) ? '0 : vote3(rd0, rd1, rd2);
  assign read_fault  = (state != ST_INIT) && DM_readEnable && rd_mis;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= next_state;
  end

  // Next state and per-cycle actions; core traffic stalls the scrubber
  always_comb begin
    next_state = state;
    init_busy  = 1'b0;
    wr_go      = 1'b0;
    inj_go     = 1'b0;
    scrub_step = 1'b0;
    scrub_fix  = 1'b0;
    scrub_bad  = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (init_idx == AW'(DEPTH - 1))
          next_state = scrub_en ? ST_SCRUB : ST_IDLE;
      end
      ST_IDLE, ST_SCRUB: begin
        wr_go      = DM_writeEnable;
        inj_go     = inject_en && (inject_copy != 2'd3) &&
                     !(DM_writeEnable && (rd_idx == inject_addr));
        next_state = scrub_en ? ST_SCRUB : ST_IDLE;
        if (state == ST_SCRUB && !DM_writeEnable && !inject_en) begin
          scrub_step = 1'b1;
          scrub_fix  = sc_maj && !sc_all;
          scrub_bad  = !sc_maj;
        end
      end
      default: next_state = ST_INIT;
    endcase
  end

  // Control registers: init sweep index, scrub pointer, saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      init_idx            <= '0;
      scrub_ptr           <= '0;
      corrected_count     <= '0;
      uncorrectable_count <= '0;
      uncorrectable_flag  <= 1'b0;
    end else begin
      if (state == ST_INIT) init_idx  <= init_idx + AW'(1);
      if (scrub_step)       scrub_ptr <= scrub_ptr + AW'(1);
      if (clear_counts) begin
        corrected_count     <= '0;
        uncorrectable_count <= '0;
        uncorrectable_flag  <= 1'b0;
      end else begin
        if (scrub_fix && corrected_count != CMAX)
          corrected_count <= corrected_count + CW'(1);
        if (scrub_bad) begin
          uncorrectable_flag <= 1'b1;
          if (uncorrectable_count != CMAX)
            uncorrectable_count <= uncorrectable_count + CW'(1);
        end
      end
    end
  end

  // Storage array; contents are cleared by the INIT sweep rather than by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        if (state == ST_INIT) begin
          mem[c][init_idx] <= '0;
        end else begin
          if (wr_go)
            mem[c][rd_idx] <= DM_writeData;
          if (inj_go && inject_copy == 2'(c))
            mem[c][inject_addr] <= mem[c][inject_addr] ^ inject_mask;
          if (scrub_fix)
            mem[c][scrub_ptr] <= sc_vote;
        end
      end
    end
  end

endmodule

// File: tb/tb_tmr_dmem_scrubber.sv
// Randomized bench for tmr_dmem_scrubber against a word-level majority model
// of the three copies, plus directed scenarios with fixed expected values.
module tb_tmr_dmem_scrubber;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned DEPTH    = 256;
  localparam int unsigned ADDR_LSB = 3;
  localparam int unsigned AW       = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] DM_addr, DM_writeData, DM_readData, inject_mask;
  logic             DM_writeEnable, DM_readEnable, scrub_en, clear_counts, inject_en;
  logic [1:0]       inject_copy;
  logic [AW-1:0]    inject_addr, scrub_ptr;
  logic             init_busy, read_fault, uncorrectable_flag;
  logic [15:0]      corrected_count, uncorrectable_count;

  always #5 clk = ~clk;

  tmr_dmem_scrubber #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_LSB(ADDR_LSB)) dut (
    .clk(clk), .reset(reset),
    .DM_addr(DM_addr), .DM_writeData(DM_writeData),
    .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
    .DM_readData(DM_readData),
    .scrub_en(scrub_en), .clear_counts(clear_counts),
    .inject_en(inject_en), .inject_copy(inject_copy),
    .inject_addr(inject_addr), .inject_mask(inject_mask),
    .init_busy(init_busy), .read_fault(read_fault), .scrub_ptr(scrub_ptr),
    .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count),
    .uncorrectable_flag(uncorrectable_flag)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [63:0] m [3][DEPTH];
  int          init_left;
  int          mptr;
  int          cc, uc;
  bit          mflag;
  bit          mscrub;

  // Number of copies equal to the most common value (1, 2 or 3)
  function automatic int agree(input int idx);
    int best, n;
    best = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      for (int j = 0; j < 3; j++) if (m[j][idx] == m[i][idx]) n++;
      if (n > best) best = n;
    end
    return best;
  endfunction

  // First copy that has company wins; without any, copy 0
  function automatic logic [63:0] majority(input int idx);
    int n;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      for (int j = 0; j < 3; j++) if (m[j][idx] == m[i][idx]) n++;
      if (n >= 2) return m[i][idx];
    end
    return m[0][idx];
  endfunction

  function automatic int index_of(input logic [63:0] a);
    return int'((a >> ADDR_LSB) % DEPTH);
  endfunction

  task automatic model_edge();
    int ri;
    logic [63:0] v;
    ri = index_of(DM_addr);
    if (reset) begin
      init_left = DEPTH; mptr = 0; cc = 0; uc = 0; mflag = 0; mscrub = 0;
      return;
    end
    if (init_left > 0) begin
      for (int c = 0; c < 3; c++) m[c][DEPTH - init_left] = '0;
      init_left--;
    end else begin
      if (mscrub && !DM_writeEnable && !inject_en) begin
        if (agree(mptr) == 2) begin
          v = majority(mptr);
          for (int c = 0; c < 3; c++) m[c][mptr] = v;
          if (cc < 65535) cc++;
        end else if (agree(mptr) == 1) begin
          if (uc < 65535) uc++;
          mflag = 1;
        end
        mptr = (mptr + 1) % DEPTH;
      end
      if (inject_en && inject_copy != 2'd3 && !(DM_writeEnable && ri == int'(inject_addr)))
        m[inject_copy][inject_addr] = m[inject_copy][inject_addr] ^ inject_mask;
      if (DM_writeEnable)
        for (int c = 0; c < 3; c++) m[c][ri] = DM_writeData;
    end
    if (clear_counts) begin cc = 0; uc = 0; mflag = 0; end
    mscrub = scrub_en;
  endtask

  // Compare all outputs against the model, then advance one clock
  task automatic tick(input bit chk = 1'b1);
    logic [63:0] ev;
    bit ef;
    int ri;
    #1;
    if (chk) begin
      ri = index_of(DM_addr);
      if (init_left > 0) begin
        ev = '0; ef = 0;
      end else begin
        ev = majority(ri);
        ef = DM_readEnable && (agree(ri) != 3);
      end
      check("rdata", DM_readData, ev);
      check("rfault", 64'(read_fault), 64'(ef));
      check("busy", 64'(init_busy), 64'(init_left > 0));
      check("ptr", 64'(scrub_ptr), 64'(mptr));
      check("ccnt", 64'(corrected_count), 64'(cc));
      check("ucnt", 64'(uncorrectable_count), 64'(uc));
      check("uflag", 64'(uncorrectable_flag), 64'(mflag));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic quiet();
    DM_writeEnable = 0; DM_readEnable = 0; inject_en = 0; clear_counts = 0;
    DM_writeData = '0; inject_mask = '0; inject_copy = 2'd0; inject_addr = '0;
  endtask

  task automatic sweep();
    scrub_en = 1;
    repeat (DEPTH) tick();
    scrub_en = 0;
    tick();
  endtask

  int cyc;
  int saved_ptr;

  initial begin
    reset = 1; scrub_en = 0; DM_addr = '0;
    quiet();
    init_left = DEPTH; mptr = 0; cc = 0; uc = 0; mflag = 0; mscrub = 0;
    tick(0);
    tick(1);
    tick(1);
    reset = 0;

    // INIT length, with a core write to index 3 that must be ignored
    cyc = 0;
    while (init_busy && cyc < 1000) begin
      DM_writeEnable = (cyc == 10);
      DM_addr        = 64'h18;
      DM_writeData   = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      cyc++;
    end
    check("init_len", 64'(cyc), 64'(DEPTH));
    quiet();
    DM_addr = 64'h18; DM_readEnable = 1;
    #1 check("init_wr_ignored", DM_readData, 64'h0);
    tick();

    // Write, read back, alias
    DM_writeEnable = 1; DM_addr = 64'h40; DM_writeData = 64'h0123456789ABCDEF;
    tick();
    quiet(); DM_readEnable = 1; DM_addr = 64'h40;
    #1 check("wr_read", DM_readData, 64'h0123456789ABCDEF);
    check("wr_fault", 64'(read_fault), 64'h0);
    tick();
    DM_readEnable = 1; DM_addr = 64'h840;
    #1 check("alias_read", DM_readData, 64'h0123456789ABCDEF);
    tick();

    // Single-copy corruption is masked but flagged
    inject_en = 1; inject_copy = 2'd1; inject_addr = 8'd8; inject_mask = 64'hFF;
    tick();
    quiet(); DM_readEnable = 1; DM_addr = 64'h40;
    #1 check("inj_read", DM_readData, 64'h0123456789ABCDEF);
    check("inj_fault", 64'(read_fault), 64'h1);
    tick();

    // One sweep repairs it
    sweep();
    DM_readEnable = 1; DM_addr = 64'h40;
    #1 check("fix_ccnt", 64'(corrected_count), 64'd1);
    check("fix_fault", 64'(read_fault), 64'h0);
    check("fix_ptr", 64'(scrub_ptr), 64'h0);
    tick();

    // No-majority word
    inject_en = 1; inject_copy = 2'd0; inject_addr = 8'd8; inject_mask = 64'h1;
    tick();
    inject_copy = 2'd1; inject_mask = 64'h2;
    tick();
    quiet();
    sweep();
    DM_readEnable = 1; DM_addr = 64'h40;
    #1 check("nomaj_read", DM_readData, 64'h0123456789ABCDEE);
    check("nomaj_ucnt", 64'(uncorrectable_count), 64'd1);
    check("nomaj_flag", 64'(uncorrectable_flag), 64'd1);
    tick();
    sweep();
    #1 check("nomaj_ucnt2", 64'(uncorrectable_count), 64'd2);
    check("nomaj_flag2", 64'(uncorrectable_flag), 64'd1);
    clear_counts = 1;
    tick();
    clear_counts = 0;
    #1 check("clr_ucnt", 64'(uncorrectable_count), 64'd0);
    check("clr_ccnt", 64'(corrected_count), 64'd0);
    check("clr_flag", 64'(uncorrectable_flag), 64'd0);
    tick();

    // Core writes stall the scrubber; reset mid-sweep
    scrub_en = 1;
    repeat (20) tick();
    saved_ptr = mptr;
    DM_writeEnable = 1; DM_addr = 64'h320; DM_writeData = 64'h5555;
    repeat (10) tick();
    DM_writeEnable = 0;
    #1 check("stall_ptr", 64'(scrub_ptr), 64'(saved_ptr));
    repeat (5) tick();
    reset = 1;
    tick();
    #1 check("rst_busy", 64'(init_busy), 64'd1);
    check("rst_ptr", 64'(scrub_ptr), 64'd0);
    check("rst_ucnt", 64'(uncorrectable_count), 64'd0);
    check("rst_ccnt", 64'(corrected_count), 64'd0);
    reset = 0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      DM_writeEnable = ($urandom % 8) == 0;
      DM_readEnable  = $urandom % 2;
      DM_addr        = {$urandom(), $urandom()};
      DM_addr[ADDR_LSB +: AW] = AW'($urandom_range(31));
      DM_writeData   = {$urandom(), $urandom()};
      inject_en      = ($urandom % 6) == 0;
      inject_copy    = 2'($urandom % 4);
      inject_addr    = AW'($urandom_range(31));
      inject_mask    = ($urandom % 2) ? (64'h1 << ($urandom % 64)) : {$urandom(), $urandom()};
      clear_counts   = ($urandom % 300) == 0;
      if (($urandom % 40) == 0) scrub_en = ~scrub_en;
      reset          = ($urandom % 1500) == 0;
      tick();
    end
    reset = 0;
    quiet();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tmr_dmem_scrubber.md
# tmr_dmem_scrubber

Triplicated data memory that answers the core's `DM_*` port, the memory side of the interface the core drives. Every word is stored in three copies. Reads return a 2-of-3 word-level vote, so the memory is fault-tolerant in the same way as the 5-ALU voted execute stage. A background scrubber walks the array, rewrites any single corrupted copy, and counts corrected and uncorrectable words. A fault-injection port exists for verification.

## Interface
- `WIDTH`, 64, data word width (matches core `#(64)`)
- `DEPTH`, 256, words per copy; must be a power of two ≥ 4
- `ADDR_LSB`, 3, byte-offset bits dropped from `DM_addr` (doubleword addressing)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `DM_addr` in WIDTH: byte address; index = `DM_addr[ADDR_LSB +: log2(DEPTH)]`; higher bits ignored (aliasing)
- `DM_writeData` in WIDTH: write data
- `DM_writeEnable` in 1: write strobe
- `DM_readEnable` in 1: read strobe; gates `read_fault` only
- `DM_readData` out WIDTH: voted read data, combinational
- `scrub_en` in 1: allows the scrubber to run
- `clear_counts` in 1: synchronously zeroes both counters and `uncorrectable_flag`
- `inject_en` in 1: fault-injection strobe
- `inject_copy` in 2: target copy 0–2; a value of 3 drops the injection
- `inject_addr` in log2(DEPTH): target index
- `inject_mask` in WIDTH: XORed into the target word
- `init_busy` out 1: high while the array is being zero-cleared
- `read_fault` out 1: copies disagree at the current read index while `DM_readEnable` is high (combinational)
- `scrub_ptr` out log2(DEPTH): next index the scrubber will examine
- `corrected_count` out 16: single-copy corrections; saturates at 0xFFFF
- `uncorrectable_count` out 16: no-majority words found by the scrubber; saturates at 0xFFFF
- `uncorrectable_flag` out 1: sticky; set on the first uncorrectable word

## Operation
- **Vote:** for copies c0, c1, c2 at an index, the result is c0 if c0==c1 or c0==c2; otherwise c1 if c1==c2; otherwise there is no majority and the result is c0. A mismatch means the three copies are not all equal.
- **FSM states:** INIT, IDLE, SCRUB.
- **INIT:**
  - Entered on reset.
  - One cycle per index, 0..DEPTH-1, writes zero to all three copies.
  - `init_busy`=1 throughout.
  - `DM_readData`=0 and `read_fault`=0.
  - Core writes and injections are ignored.
  - After index DEPTH-1 is written, the next state is SCRUB if `scrub_en`=1, else IDLE.
- **IDLE ↔ SCRUB:** follows `scrub_en`, evaluated every cycle. `scrub_ptr` holds its value in IDLE.
- **Core write (not INIT):** writes `DM_writeData` to all three copies at the index.
- **Injection (not INIT):**
  - XORs `inject_mask` into copy `inject_copy` at `inject_addr`.
  - If a core write targets the same index in the same cycle, the core write wins and the injection is dropped.
- **SCRUB cycle:**
  - If `DM_writeEnable` or `inject_en` is high, the scrubber stalls and the pointer holds.
  - Otherwise it votes the words at `scrub_ptr`:
    - All copies equal: no action.
    - Majority with a mismatch: write the majority value to all three copies and increment `corrected_count`.
    - No majority: leave the copies unchanged, increment `uncorrectable_count`, and set `uncorrectable_flag`.
  - Then `scrub_ptr` increments, wrapping DEPTH-1 → 0.
- **Read path:** never writes back; only the scrubber corrects.
- **Counters:**
  - If `clear_counts` and an increment occur in the same cycle, the clear wins.
  - Counters saturate and do not wrap.

## Timing
- **Read latency:** 0 cycles (combinational from `DM_addr` and array state).
- **Writes:** visible on the cycle after the edge. A read of the same index in the same cycle as the write returns the old data.
- **Scrub correction:** visible the cycle after the SCRUB cycle in which it is performed.
- **Reset values:**
  - FSM=INIT, `init_busy`=1, `scrub_ptr`=0.
  - Both counts=0, `uncorrectable_flag`=0.
  - `DM_readData`=0, `read_fault`=0.
- **INIT duration:** after the first edge with `reset`=0, `init_busy` stays high for exactly DEPTH cycles and falls on edge DEPTH.
- **Reset mid-operation:** aborts any state, reloads all reset values, and restarts INIT from index 0.
- **Full sweep time:** DEPTH unstalled SCRUB cycles.

## Test plan
1. Reset for 2 cycles, then release; DEPTH=256 → `init_busy` falls after exactly 256 cycles; reading `DM_addr`=0x18 returns 0; a write issued during INIT has no effect.
2. Write 0x0123456789ABCDEF to 0x40 → on the next cycle a read of 0x40 returns 0x0123456789ABCDEF with `read_fault`=0; a read of 0x840 (aliases with DEPTH=256) returns the same value.
3. Inject `inject_copy`=1, `inject_addr`=8, mask 0xFF → a read of 0x40 returns 0x0123456789ABCDEF with `read_fault`=1.
4. From test 3, set `scrub_en`=1 for 256 cycles → `corrected_count`=1; a read of 0x40 now gives `read_fault`=0; `scrub_ptr` is back at 0.
5. Inject mask 0x1 into copy 0 and mask 0x2 into copy 1 at index 8, then scrub → a read returns 0x0123456789ABCDEE (copy 0); `uncorrectable_count`=1; `uncorrectable_flag`=1 and stays set after a second sweep with `uncorrectable_count`=2; `clear_counts` zeroes all three.
6. Hold `DM_writeEnable` for 10 cycles during SCRUB → `scrub_ptr` is unchanged; then assert `reset` mid-sweep → counts 0, `init_busy`=1, `scrub_ptr`=0.
